// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execute unit driven by the 4-bit ALU control code.
// Logic, arithmetic, compare and LUI finish in one cycle; SLL/SRL/SRA shift
// one bit position per cycle. The result and its flags are held until the
// consumer takes them.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   alu_ctrl            operation code
//   operand_a/operand_b operands (operand_b is the shifted operand)
//   shamt               shift amount
//   out_valid/out_ready result handshake
//   result, zero        registered result and result==0 flag
//   overflow            signed overflow for ADD/SUB
//   illegal             alu_ctrl was not a defined code
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               illegal
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpXor = 4'b0011;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSgt = 4'b0101;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpSrl = 4'b1000;
    localparam logic [3:0] OpSra = 4'b1001;
    localparam logic [3:0] OpLui = 4'b1010;
    localparam logic [3:0] OpNor = 4'b1100;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [1:0] {KindSll, KindSrl, KindSra} kind_e;

    state_e             state_q, state_d;
    kind_e              kind_q, shift_kind;
    logic [WIDTH-1:0]   work_q, work_shifted;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q, overflow_q, illegal_q;

    logic               is_shift, accept, load_alu, load_shift, shift_step, shift_done;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ov, alu_ill;

    assign is_shift = (alu_ctrl == OpSll) || (alu_ctrl == OpSrl) || (alu_ctrl == OpSra);

    // Single-cycle datapath
    always_comb begin
        sum     = operand_a + operand_b;
        diff    = operand_a - operand_b;
        alu_res = '0;
        alu_ov  = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OpAnd: alu_res = operand_a & operand_b;
            OpOr:  alu_res = operand_a | operand_b;
            OpXor: alu_res = operand_a ^ operand_b;
            OpNor: alu_res = ~(operand_a | operand_b);
            OpAdd: begin
                alu_res = sum;
                alu_ov  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_ov  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OpSgt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) > $signed(operand_b))};
            OpLui: alu_res = operand_b << (WIDTH / 2);
            // Shift codes are handled by the iterative path
            OpSll, OpSrl, OpSra: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        shift_kind = KindSll;
        if (alu_ctrl == OpSrl) begin
            shift_kind = KindSrl;
        end else if (alu_ctrl == OpSra) begin
            shift_kind = KindSra;
        end
    end

    always_comb begin
        work_shifted = work_q << 1;
        case (kind_q)
            KindSrl: work_shifted = work_q >> 1;
            KindSra: work_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: work_shifted = work_q << 1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = is_shift ? StShift : StDone;
            StShift: if (cnt_q == '0) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and datapath strobes
    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = (state_q == StDone);
        accept     = in_ready && in_valid;
        load_alu   = accept && !is_shift;
        load_shift = accept && is_shift;
        shift_step = (state_q == StShift) && (cnt_q != '0);
        shift_done = (state_q == StShift) && (cnt_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q     <= '0;
            cnt_q      <= '0;
            kind_q     <= KindSll;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (load_alu) begin
            result_q   <= alu_res;
            zero_q     <= (alu_res == '0);
            overflow_q <= alu_ov;
            illegal_q  <= alu_ill;
        end else if (load_shift) begin
            work_q     <= operand_b;
            cnt_q      <= shamt;
            kind_q     <= shift_kind;
        end else if (shift_step) begin
            work_q     <= work_shifted;
            cnt_q      <= cnt_q - SHAMT_W'(1);
        end else if (shift_done) begin
            result_q   <= work_q;
            zero_q     <= (work_q == '0);
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule
